// File: rtl/run_control_unit_if.sv
// Host-side bus of the run controller: core observation inputs, run-control
// pulses and the status/enable outputs back to the core and debug host.
interface run_control_unit_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]  instruction_i;
    logic [ADDR_WIDTH-1:0]  pc_i;
    logic                   step_mode_i;
    logic                   step_i;
    logic                   resume_i;
    logic                   restart_i;
    logic                   bp_enable_i;
    logic [ADDR_WIDTH-1:0]  bp_addr_i;
    logic                   core_reset_o;
    logic                   core_enable_o;
    logic                   halted_o;
    logic [1:0]             halt_cause_o;
    logic [ADDR_WIDTH-1:0]  halt_pc_o;
    logic [COUNT_WIDTH-1:0] retired_count_o;

    modport master (
        output instruction_i, pc_i, step_mode_i, step_i, resume_i, restart_i,
               bp_enable_i, bp_addr_i,
        input  core_reset_o, core_enable_o, halted_o, halt_cause_o, halt_pc_o,
               retired_count_o
    );

    modport slave (
        input  instruction_i, pc_i, step_mode_i, step_i, resume_i, restart_i,
               bp_enable_i, bp_addr_i,
        output core_reset_o, core_enable_o, halted_o, halt_cause_o, halt_pc_o,
               retired_count_o
    );
endinterface

// File: rtl/run_control_unit.sv
// Run controller for the single-cycle core: sequences core reset, gates commit
// and stops on halt word, PC breakpoint or watchdog expiry.
module run_control_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD    = '0,
    parameter int                    RESET_CYCLES = 2,
    parameter int                    COUNT_WIDTH  = 32,
    parameter int                    TIMEOUT      = 0
) (
    input logic               clk_i,
    input logic               rst_i,
    run_control_unit_if.slave bus
);
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] TO_LAST   = COUNT_WIDTH'(TIMEOUT - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_HALT = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd2;
    localparam logic [1:0] CAUSE_TO   = 2'd3;

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_PAUSED, S_HALTED} state_t;

    state_t                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;
    logic [COUNT_WIDTH-1:0] wdog_q, wdog_d;
    logic [1:0]             cause_q, cause_d;
    logic [ADDR_WIDTH-1:0]  hpc_q, hpc_d;
    logic                   suppress_q, suppress_d;
    logic                   core_reset_q;
    logic                   core_en;
    logic                   halt_hit, bp_hit, to_hit;

    always_comb begin
        halt_hit = (bus.instruction_i == HALT_WORD);
        bp_hit   = bus.bp_enable_i && (bus.pc_i == bus.bp_addr_i) && !suppress_q;
        to_hit   = (TIMEOUT != 0) && (wdog_q == TO_LAST);
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        retired_d  = retired_q;
        wdog_d     = wdog_q;
        cause_d    = cause_q;
        hpc_d      = hpc_q;
        suppress_d = suppress_q;
        core_en    = 1'b0;

        case (state_q)
            S_HOLD: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = bus.step_mode_i ? S_PAUSED : S_RUN;
                end
            end
            S_RUN: begin
                core_en = !halt_hit && !bp_hit;
                if (halt_hit) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_HALT;
                    hpc_d   = bus.pc_i;
                end else if (bp_hit) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_BP;
                    hpc_d   = bus.pc_i;
                end else if (to_hit) begin
                    // The expiring instruction still commits this cycle.
                    state_d = S_HALTED;
                    cause_d = CAUSE_TO;
                    hpc_d   = bus.pc_i;
                end
            end
            S_PAUSED: begin
                core_en = bus.step_i && !halt_hit;
                if (bus.step_i) begin
                    if (halt_hit) begin
                        state_d = S_HALTED;
                        cause_d = CAUSE_HALT;
                        hpc_d   = bus.pc_i;
                    end else if (to_hit) begin
                        state_d = S_HALTED;
                        cause_d = CAUSE_TO;
                        hpc_d   = bus.pc_i;
                    end
                end else if (bus.resume_i) begin
                    state_d = S_RUN;
                end
            end
            S_HALTED: begin
                // A halt-word stop is terminal until restart; only BP/timeout resume.
                if (bus.resume_i && cause_q == CAUSE_BP) begin
                    state_d    = S_RUN;
                    suppress_d = 1'b1;
                    cause_d    = CAUSE_NONE;
                    hpc_d      = '0;
                end else if (bus.resume_i && cause_q == CAUSE_TO) begin
                    state_d = S_RUN;
                    wdog_d  = '0;
                    cause_d = CAUSE_NONE;
                    hpc_d   = '0;
                end
            end
            default: state_d = S_HOLD;
        endcase

        if (core_en) begin
            if (retired_q != CNT_MAX) retired_d = retired_q + COUNT_WIDTH'(1);
            if (wdog_q != CNT_MAX)    wdog_d    = wdog_q + COUNT_WIDTH'(1);
            suppress_d = 1'b0;
        end

        if (bus.restart_i) begin
            state_d    = S_HOLD;
            hold_d     = '0;
            retired_d  = '0;
            wdog_d     = '0;
            cause_d    = CAUSE_NONE;
            hpc_d      = '0;
            suppress_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_HOLD;
            hold_q       <= '0;
            retired_q    <= '0;
            wdog_q       <= '0;
            cause_q      <= CAUSE_NONE;
            hpc_q        <= '0;
            suppress_q   <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            retired_q    <= retired_d;
            wdog_q       <= wdog_d;
            cause_q      <= cause_d;
            hpc_q        <= hpc_d;
            suppress_q   <= suppress_d;
            core_reset_q <= (state_d == S_HOLD);
        end
    end

    assign bus.core_reset_o    = core_reset_q;
    assign bus.core_enable_o   = core_en;
    assign bus.halted_o        = (state_q == S_HALTED);
    assign bus.halt_cause_o    = cause_q;
    assign bus.halt_pc_o       = hpc_q;
    assign bus.retired_count_o = retired_q;
endmodule
